pwm_update_scheduler: RTL
=========================

Name: pwm_update_scheduler

Overview:
- Generates 16 output channels from the SPI-written configuration bytes: enable masks, PWM-select masks and a shared 8-bit duty cycle.
- Sits between the SPI register file and the output pins.
- Owns a clock prescaler, an 8-bit period counter and shadow registers.
- Configuration changes reach the pins only at a period boundary, so every PWM pulse has a whole, glitch-free width.

Parameters:
- CLK_DIV, 4, clk cycles per PWM counter tick; legal range 1..65535.
- PERIOD_STEPS, 255, counter steps per PWM period; the counter runs 0..PERIOD_STEPS-1; fixed at 255 for 8-bit duty.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- en_reg_out_7_0  input  8  output enable, channels 7..0
- en_reg_out_15_8  input  8  output enable, channels 15..8
- en_reg_pwm_7_0  input  8  PWM select, channels 7..0
- en_reg_pwm_15_8  input  8  PWM select, channels 15..8
- pwm_duty_cycle  input  8  shared duty; 0x00 = 0%, 0xFF = 100%
- cfg_valid  input  1  one-cycle pulse; the register inputs already hold the new values in this cycle
- out  output  16  channel outputs (registered)
- period_start  output  1  one-cycle pulse in the cycle the counter returns to 0
- update_pending  output  1  a configuration change is waiting for the next boundary

Behaviour:
- One clock domain: clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - out = 0, period_start = 0, update_pending = 0.
  - Prescaler = 0, counter = 0.
  - Shadow PWM mask = 0, shadow duty = 0.
- Prescaler:
  - Counts 0..CLK_DIV-1 and wraps.
  - tick is asserted when the prescaler equals CLK_DIV-1.
  - CLK_DIV = 1 means tick on every cycle.
- Counter:
  - Advances by 1 on each tick.
  - On a tick at PERIOD_STEPS-1 it wraps to 0; that same edge registers period_start = 1 for one cycle.
  - Period length = PERIOD_STEPS*CLK_DIV clk cycles.
- Shadow load (the "boundary"):
  - Occurs on the wrap edge when update_pending = 1, or when cfg_valid and the wrap fall in the same cycle.
  - Shadow PWM mask and shadow duty take their values from the live inputs.
  - update_pending clears.
- cfg_valid with no wrap in the same cycle: update_pending is set and stays set until the next boundary.
- Simultaneous cfg_valid and wrap: the shadow loads the current inputs and update_pending stays 0.
- A repeated cfg_valid while pending: no extra effect; the next boundary captures the latest inputs.
- Enable masks are not shadowed. A change on en_reg_out appears on out on the next clk edge, so disables are immediate.
- PWM level: pwm_lvl = (shadow_duty == 0xFF) | (counter < shadow_duty), an unsigned 8-bit compare.
  - Duty 0x00 gives a constant 0.
  - Duty 0x80 gives 128 high steps out of 255.
- Per channel i, registered with 1-cycle latency: out[i] = en_out[i] & (shadow_pwm[i] ? pwm_lvl : 1).
- Reset mid-period: all state returns to reset values immediately; counting restarts from 0 after rst_n deasserts.
- The block has no backpressure; cfg_valid is never lost.

Optional Feature:
- Macro: PWM_FORCE_UPDATE_EN.
- When defined:
  - Adds input port force_update (1 bit).
  - A force_update pulse loads the shadow registers from the live inputs, clears the prescaler and counter to 0, clears update_pending, and pulses period_start on the next edge.
  - force_update has priority over a coincident wrap or cfg_valid.
- When undefined: the port is absent and updates happen only at natural boundaries.

Test Plan:
- Reset with en_reg_out = 0xFFFF, PWM masks 0, duty 0x80 -> out = 0 during reset; out = 0xFFFF one cycle after the first active edge following reset release.
- PWM masks = 0xFFFF, duty 0x80, cfg_valid, CLK_DIV = 4 -> update_pending stays high until the first wrap. After that each channel is high for 512 clk cycles and low for 508, with period_start every 1020 cycles.
- Duty changed from 0x40 to 0xC0 mid-period, cfg_valid -> the current period keeps the 0x40 high time (256 cycles); the next period shows 768 high cycles; no runt pulse.
- Duty 0xFF -> PWM channels constantly 1. Duty 0x00 -> constantly 0. Both hold across the wrap.
- en_reg_out_7_0 changed from 0xFF to 0x00 mid-period -> out[7:0] = 0 one cycle later, without waiting for the boundary.
- cfg_valid in the same cycle as the wrap tick -> shadow updated at that wrap and update_pending never asserts. With PWM_FORCE_UPDATE_EN, force_update at counter 100 -> counter = 0 and period_start one cycle later.

Source files
------------

// File: rtl/pwm_update_scheduler.sv
// pwm_update_scheduler: 16-channel PWM/static output stage with period-aligned
// configuration updates. Duty and PWM-select masks are shadowed and only take
// effect at a period boundary. Enable masks act on the next clock edge.
// Optional feature macro: PWM_FORCE_UPDATE_EN adds a force_update input that
// restarts the period and loads the shadow registers immediately.
module pwm_update_scheduler #(
    parameter int CLK_DIV      = 4,
    parameter int PERIOD_STEPS = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
`ifdef PWM_FORCE_UPDATE_EN
    input  logic        force_update,
`endif
    input  logic        cfg_valid,
    output logic [15:0] out,
    output logic        period_start,
    output logic        update_pending
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);
    localparam logic [7:0]    CNT_MAX = 8'(PERIOD_STEPS - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [15:0]   spwm_q, spwm_d;
    logic [7:0]    sduty_q, sduty_d;
    logic          pend_q, pend_d;
    logic          ps_q, ps_d;
    logic [15:0]   out_q, out_d;

    logic        tick, wrap, load, pwm_lvl;
    logic [15:0] en_out;
    logic        frc;

`ifdef PWM_FORCE_UPDATE_EN
    assign frc = force_update;
`else
    assign frc = 1'b0;
`endif

    assign en_out = {en_reg_out_15_8, en_reg_out_7_0};

    // Next-state: prescaler/counter timing, boundary shadow load, output levels
    always_comb begin
        presc_d = presc_q;
        cnt_d   = cnt_q;
        spwm_d  = spwm_q;
        sduty_d = sduty_q;
        pend_d  = pend_q;
        ps_d    = 1'b0;

        tick = (presc_q == PRE_MAX);
        wrap = tick && (cnt_q == CNT_MAX);
        // A cfg_valid coinciding with the wrap is served by this boundary directly.
        load = wrap && (pend_q || cfg_valid);

        // Compare uses the shadow duty so a pulse never changes width mid-period.
        pwm_lvl = (sduty_q == 8'hFF) || (cnt_q < sduty_q);
        out_d   = en_out & (~spwm_q | {16{pwm_lvl}});

        if (frc) begin
            // Forced restart wins over any coincident wrap or cfg_valid.
            presc_d = '0;
            cnt_d   = '0;
            spwm_d  = {en_reg_pwm_15_8, en_reg_pwm_7_0};
            sduty_d = pwm_duty_cycle;
            pend_d  = 1'b0;
            ps_d    = 1'b1;
        end else begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (tick) cnt_d = wrap ? 8'd0 : cnt_q + 8'd1;
            ps_d = wrap;
            if (load) begin
                spwm_d  = {en_reg_pwm_15_8, en_reg_pwm_7_0};
                sduty_d = pwm_duty_cycle;
                pend_d  = 1'b0;
            end else if (cfg_valid) begin
                pend_d = 1'b1;
            end
        end
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            cnt_q   <= '0;
            spwm_q  <= '0;
            sduty_q <= '0;
            pend_q  <= 1'b0;
            ps_q    <= 1'b0;
            out_q   <= '0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            spwm_q  <= spwm_d;
            sduty_q <= sduty_d;
            pend_q  <= pend_d;
            ps_q    <= ps_d;
            out_q   <= out_d;
        end
    end

    assign out            = out_q;
    assign period_start   = ps_q;
    assign update_pending = pend_q;

endmodule
